// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the word-addressed data memory.
// Port 0 (load/store unit) normally wins. Port 1 (DMA/debug) is forced through after
// STARVE_LIMIT consecutive denied cycles. Load data is registered into a one-cycle-later
// response to the port that was granted.
// Optional feature: define DMEM_ARB_LOCK_EN to let a port take ownership with reqN_lock_i.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_wmem_i,
  input  logic [4:0]        req0_rmem_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [31:0]       req0_wdata_i,
  input  logic              req0_lock_i,
  output logic              rsp0_valid_o,
  output logic [31:0]       rsp0_data_o,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_wmem_i,
  input  logic [4:0]        req1_rmem_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [31:0]       req1_wdata_i,
  input  logic              req1_lock_i,
  output logic              rsp1_valid_o,
  output logic [31:0]       rsp1_data_o,
  output logic [3:0]        wmem_o,
  output logic [4:0]        rmem_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       store_data_o,
  input  logic [31:0]       load_data_i
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  logic             gnt0, gnt1;
  logic             owned0, owned1;
  logic             starve_hit;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [31:0]      rsp0_data_q, rsp1_data_q;

  assign starve_hit = (starve_q == StarveMax);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {OwnNone, Own0, Own1} owner_e;
  owner_e owner_q, owner_d;

  // Ownership only counts while the owner is still requesting; a dropped valid frees
  // the other port in the same cycle so no bubble is inserted.
  assign owned0 = (owner_q == Own0) && req0_valid_i;
  assign owned1 = (owner_q == Own1) && req1_valid_i;

  // Owner next state: a granted transfer sets or clears ownership by its lock bit
  always_comb begin
    owner_d = owner_q;
    if ((owner_q == Own0 && !req0_valid_i) || (owner_q == Own1 && !req1_valid_i)) begin
      owner_d = OwnNone;
    end
    if (gnt0) begin
      owner_d = req0_lock_i ? Own0 : OwnNone;
    end else if (gnt1) begin
      owner_d = req1_lock_i ? Own1 : OwnNone;
    end
  end

  // Owner state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OwnNone;
    end else begin
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = req0_lock_i ^ req1_lock_i;
  assign owned0      = 1'b0;
  assign owned1      = 1'b0;
`endif

  // Grant decision; everything is forced low while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      gnt1 = req1_valid_i && !owned0 && (owned1 || !req0_valid_i || starve_hit);
      gnt0 = req0_valid_i && !gnt1 && !owned1;
    end
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Memory port mux: winner's fields pass unchanged, all zero when idle
  always_comb begin
    wmem_o       = '0;
    rmem_o       = '0;
    mem_addr_o   = '0;
    store_data_o = '0;
    if (gnt0) begin
      wmem_o       = req0_wmem_i;
      rmem_o       = req0_rmem_i;
      mem_addr_o   = req0_addr_i;
      store_data_o = req0_wdata_i;
    end else if (gnt1) begin
      wmem_o       = req1_wmem_i;
      rmem_o       = req1_rmem_i;
      mem_addr_o   = req1_addr_i;
      store_data_o = req1_wdata_i;
    end
  end

  // Starvation counter next state: counts denied port 1 cycles, saturating
  always_comb begin
    starve_d = starve_q;
    if (!req1_valid_i || gnt1) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      rsp0_valid_q <= gnt0 && (req0_rmem_i != 5'd0);
      rsp1_valid_q <= gnt1 && (req1_rmem_i != 5'd0);
      if (gnt0 && (req0_rmem_i != 5'd0)) begin
        rsp0_data_q <= load_data_i;
      end
      if (gnt1 && (req1_rmem_i != 5'd0)) begin
        rsp1_data_q <= load_data_i;
      end
    end
  end

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_data_o  = rsp1_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, a word-addressed memory with lane packing,
// a per-cycle reference model of the arbitration rules, and literal spot checks.
module tb_dmem_arbiter;

  localparam int StarveLimit = 8;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        v[2];
  logic        rdy[2];
  logic [3:0]  wm[2];
  logic [4:0]  rm[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic        lk[2];
  logic        rv[2];
  logic [31:0] rd[2];
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  logic [31:0] mem[64];

  int n_pass  = 0;
  int n_total = 0;

  dmem_arbiter #(
    .ADDR_W      (32),
    .STARVE_LIMIT(StarveLimit),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid_i(v[0]),
    .req0_ready_o(rdy[0]),
    .req0_wmem_i (wm[0]),
    .req0_rmem_i (rm[0]),
    .req0_addr_i (ad[0]),
    .req0_wdata_i(wd[0]),
    .req0_lock_i (lk[0]),
    .rsp0_valid_o(rv[0]),
    .rsp0_data_o (rd[0]),
    .req1_valid_i(v[1]),
    .req1_ready_o(rdy[1]),
    .req1_wmem_i (wm[1]),
    .req1_rmem_i (rm[1]),
    .req1_addr_i (ad[1]),
    .req1_wdata_i(wd[1]),
    .req1_lock_i (lk[1]),
    .rsp1_valid_o(rv[1]),
    .rsp1_data_o (rd[1]),
    .wmem_o      (wmem),
    .rmem_o      (rmem),
    .mem_addr_o  (mem_addr),
    .store_data_o(store_data),
    .load_data_i (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected lanes are gathered into the low bytes, then optionally sign-extended.
  function automatic logic [31:0] mem_load(logic [31:0] w, logic [4:0] code);
    logic [31:0] r;
    int k;
    r = '0;
    k = 0;
    for (int b = 0; b < 4; b++) begin
      if (code[b]) begin
        r[8*k +: 8] = w[8*b +: 8];
        k++;
      end
    end
    if (code[4] && k > 0 && k < 4 && r[8*k-1]) begin
      for (int j = k; j < 4; j++) r[8*j +: 8] = 8'hFF;
    end
    return r;
  endfunction

  // Low bytes of data are scattered into the selected lanes.
  function automatic logic [31:0] mem_store(logic [31:0] w, logic [31:0] d, logic [3:0] ln);
    logic [31:0] r;
    int k;
    r = w;
    k = 0;
    for (int b = 0; b < 4; b++) begin
      if (ln[b]) begin
        r[8*b +: 8] = d[8*k +: 8];
        k++;
      end
    end
    return r;
  endfunction

  always_comb load_data = mem_load(mem[mem_addr[5:0]], rmem);

  always @(posedge clk) begin
    if (wmem != 4'd0) mem[mem_addr[5:0]] <= mem_store(mem[mem_addr[5:0]], store_data, wmem);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  int          m_starve;
  int          m_owner;
  logic        m_rv[2];
  logic [31:0] m_rd[2];
  int          w;
  bit          own0, own1;

  // Per-cycle comparison against the model; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready0", 32'(rdy[0]), 32'd0);
      chk("rst_ready1", 32'(rdy[1]), 32'd0);
      chk("rst_wmem", 32'(wmem), 32'd0);
      chk("rst_rmem", 32'(rmem), 32'd0);
      chk("rst_rsp0_valid", 32'(rv[0]), 32'd0);
      chk("rst_rsp1_valid", 32'(rv[1]), 32'd0);
      m_starve = 0;
      m_owner  = -1;
      m_rv[0]  = 1'b0;
      m_rv[1]  = 1'b0;
      m_rd[0]  = '0;
      m_rd[1]  = '0;
    end else begin
      own0 = LockEn && m_owner == 0 && v[0];
      own1 = LockEn && m_owner == 1 && v[1];
      if (own1) w = 1;
      else if (own0) w = 0;
      else if (v[0] && v[1]) w = (m_starve >= StarveLimit) ? 1 : 0;
      else if (v[0]) w = 0;
      else if (v[1]) w = 1;
      else w = -1;

      chk("m_ready0", 32'(rdy[0]), 32'(w == 0));
      chk("m_ready1", 32'(rdy[1]), 32'(w == 1));
      chk("m_wmem", 32'(wmem), (w >= 0) ? 32'(wm[w]) : 32'd0);
      chk("m_rmem", 32'(rmem), (w >= 0) ? 32'(rm[w]) : 32'd0);
      chk("m_addr", mem_addr, (w >= 0) ? ad[w] : 32'd0);
      chk("m_wdata", store_data, (w >= 0) ? wd[w] : 32'd0);
      chk("m_rsp0_valid", 32'(rv[0]), 32'(m_rv[0]));
      chk("m_rsp1_valid", 32'(rv[1]), 32'(m_rv[1]));
      chk("m_rsp0_data", rd[0], m_rd[0]);
      chk("m_rsp1_data", rd[1], m_rd[1]);

      // Advance the model to what must hold after the coming rising edge
      for (int p = 0; p < 2; p++) begin
        m_rv[p] = (w == p) && (rm[p] != 5'd0);
        if (m_rv[p]) m_rd[p] = mem_load(mem[ad[p][5:0]], rm[p]);
      end
      if (v[1] && w != 1) m_starve = (m_starve < StarveLimit) ? m_starve + 1 : StarveLimit;
      else m_starve = 0;
      if ((m_owner == 0 && !v[0]) || (m_owner == 1 && !v[1])) m_owner = -1;
      if (LockEn && w >= 0) m_owner = lk[w] ? w : -1;
    end
  end

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      v[p]  = 1'b0;
      wm[p] = '0;
      rm[p] = '0;
      ad[p] = '0;
      wd[p] = '0;
      lk[p] = 1'b0;
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[16] = 32'hDEAD_BEEF;
    idle();
    rst_n = 1'b0;
    at_pos();
    at_pos();
    rst_n = 1'b1;

    // Port 0 load of 0xDEADBEEF
    v[0] = 1'b1; ad[0] = 32'h10; rm[0] = 5'b01111;
    at_neg();
    chk("t2_ready0", 32'(rdy[0]), 32'd1);
    at_pos();
    idle();
    at_neg();
    chk("t2_rsp0_valid", 32'(rv[0]), 32'd1);
    chk("t2_rsp0_data", rd[0], 32'hDEAD_BEEF);
    at_neg();
    chk("t2_rsp0_single", 32'(rv[0]), 32'd0);

    // Port 1 halfword store then sign-extended read back by port 0
    at_pos();
    v[1] = 1'b1; wm[1] = 4'b1100; wd[1] = 32'h0000_ABCD; ad[1] = 32'd3;
    at_neg();
    chk("t4_wmem", 32'(wmem), 32'b1100);
    chk("t4_addr", mem_addr, 32'd3);
    chk("t4_ready1", 32'(rdy[1]), 32'd1);
    at_pos();
    idle();
    v[0] = 1'b1; rm[0] = 5'b11100; ad[0] = 32'd3;
    at_pos();
    idle();
    at_neg();
    chk("t4_rsp0_data", rd[0], 32'hFFFF_ABCD);

    // Both valid continuously: 8 port 0 grants, then port 1
    at_pos();
    v[0] = 1'b1; rm[0] = 5'b01111; ad[0] = 32'h10;
    v[1] = 1'b1; rm[1] = 5'b01111; ad[1] = 32'd3;
    for (int i = 0; i < 9; i++) begin
      at_neg();
      chk("t3_ready0", 32'(rdy[0]), 32'(i < 8));
      chk("t3_ready1", 32'(rdy[1]), 32'(i == 8));
    end
    at_neg();
    chk("t3_after_ready0", 32'(rdy[0]), 32'd1);
    chk("t3_rsp1_data", rd[1], 32'hABCD_0000);
    at_pos();
    idle();

    // Alternating single-port loads 0,1,0
    at_pos();
    v[0] = 1'b1; rm[0] = 5'b01111; ad[0] = 32'h10;
    at_pos();
    idle();
    v[1] = 1'b1; rm[1] = 5'b01111; ad[1] = 32'd3;
    at_neg();
    chk("t5_rsp0_a", 32'(rv[0]), 32'd1);
    chk("t5_rsp1_a", 32'(rv[1]), 32'd0);
    at_pos();
    idle();
    v[0] = 1'b1; rm[0] = 5'b01111; ad[0] = 32'h10;
    at_neg();
    chk("t5_rsp0_b", 32'(rv[0]), 32'd0);
    chk("t5_rsp1_b", 32'(rv[1]), 32'd1);
    chk("t5_rsp1_data", rd[1], 32'hABCD_0000);
    at_pos();
    idle();
    at_neg();
    chk("t5_rsp0_c", 32'(rv[0]), 32'd1);
    chk("t5_rsp1_c", 32'(rv[1]), 32'd0);

`ifdef DMEM_ARB_LOCK_EN
    // Port 1 takes a lock; port 0 is held off until port 1 transfers with lock=0
    at_pos();
    v[1] = 1'b1; lk[1] = 1'b1; ad[1] = 32'd5;
    at_neg();
    chk("t6_lock_grant", 32'(rdy[1]), 32'd1);
    at_pos();
    v[0] = 1'b1; rm[0] = 5'b01111; ad[0] = 32'h10;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      chk("t6_ready0_blocked", 32'(rdy[0]), 32'd0);
    end
    at_pos();
    lk[1] = 1'b0;
    at_neg();
    chk("t6_unlock_ready1", 32'(rdy[1]), 32'd1);
    at_pos();
    v[1] = 1'b0; lk[1] = 1'b0;
    at_neg();
    chk("t6_ready0_after", 32'(rdy[0]), 32'd1);
    at_pos();
    idle();
`endif

    // Reset asserted mid-grant with a port 0 load pending
    at_pos();
    v[0] = 1'b1; rm[0] = 5'b01111; ad[0] = 32'h10;
    at_neg();
    chk("t1_pre_ready0", 32'(rdy[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_ready0", 32'(rdy[0]), 32'd0);
    chk("t1_rmem", 32'(rmem), 32'd0);
    chk("t1_wmem", 32'(wmem), 32'd0);
    at_pos();
    chk("t1_rsp0_valid", 32'(rv[0]), 32'd0);
    chk("t1_rsp0_data", rd[0], 32'd0);
    idle();
    at_pos();
    rst_n = 1'b1;
    at_neg();
    at_neg();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
